// File: rtl/game_pkg.sv
// Shared constants for the flappy-bird pipeline: status encoding seen by the
// bird physics block, screen limits and bird sprite geometry.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } status_t;

    localparam int FLOOR_Y    = 465;
    localparam int CEIL_Y     = 25;
    localparam int BIRD_X     = 100;
    localparam int BIRD_W     = 20;
    localparam int BIRD_H     = 20;
    localparam int BCD_DIGITS = 2;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with synchronous clear and increment; 99 wraps to 00.
module bcd2_counter
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [7:0] o_q
);

    // w_carry[gi] is the increment request arriving at digit gi
    logic [BCD_DIGITS-1:0] w_carry;

    assign w_carry[0] = i_inc;

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            logic [3:0] r_digit;
            logic       w_wrap;

            assign w_wrap = (r_digit == 4'd9);

            if (gi < BCD_DIGITS - 1) begin : g_carry
                assign w_carry[gi+1] = w_carry[gi] & w_wrap;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_digit <= 4'd0;
                end else if (i_clr) begin
                    r_digit <= 4'd0;
                end else if (w_carry[gi]) begin
                    r_digit <= w_wrap ? 4'd0 : r_digit + 4'd1;
                end
            end

            assign o_q[gi*4 +: 4] = r_digit;
        end
    endgenerate

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: IDLE/READY/PLAY/OVER sequencing, bird/pipe and
// bird/floor collision detection, and the BCD pass score.
module game_ctrl #(
    parameter int BIRD_X      = game_pkg::BIRD_X,
    parameter int BIRD_W      = game_pkg::BIRD_W,
    parameter int BIRD_H      = game_pkg::BIRD_H,
    parameter int PIPE_W      = 60,
    parameter int GAP_H       = 150,
    parameter int FLOOR_Y     = game_pkg::FLOOR_Y,
    parameter int READY_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic signed [10:0] i_bird_y,
    input  logic signed [10:0] i_pipe_x,
    input  logic signed [10:0] i_gap_y,
    output logic [1:0]         o_status,
    output logic [7:0]         o_score,
    output logic               o_game_over
);
    import game_pkg::*;

    localparam int CNT_W = (READY_TICKS > 2) ? $clog2(READY_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READY_TICKS - 1);

    localparam logic signed [11:0] C_BIRD_L = 12'(BIRD_X);
    localparam logic signed [11:0] C_BIRD_R = 12'(BIRD_X + BIRD_W);
    localparam logic signed [11:0] C_BIRD_H = 12'(BIRD_H);
    localparam logic signed [11:0] C_PIPE_W = 12'(PIPE_W);
    localparam logic signed [11:0] C_GAP_H  = 12'(GAP_H);
    localparam logic signed [11:0] C_FLOOR  = 12'(FLOOR_Y);

    status_t          r_state;
    status_t          w_state_next;
    logic             r_start_q;
    logic [CNT_W-1:0] r_ready_cnt;
    logic             r_prev_passed;
    logic             r_game_over;

    logic w_start_rise, w_step, w_enter_ready;
    logic w_x_overlap, w_pipe_hit, w_floor_hit, w_hit, w_passed;
    logic w_score_clr, w_score_inc;

    // 12-bit sign-extended geometry so sums near the 11-bit limits cannot wrap
    logic signed [11:0] w_bird_y, w_pipe_x, w_gap_y;
    logic signed [11:0] w_pipe_r, w_bird_b, w_gap_b;

    assign w_bird_y = {i_bird_y[10], i_bird_y};
    assign w_pipe_x = {i_pipe_x[10], i_pipe_x};
    assign w_gap_y  = {i_gap_y[10], i_gap_y};
    assign w_pipe_r = w_pipe_x + C_PIPE_W;
    assign w_bird_b = w_bird_y + C_BIRD_H;
    assign w_gap_b  = w_gap_y + C_GAP_H;

    assign w_x_overlap = (w_pipe_x < C_BIRD_R) && (w_pipe_r > C_BIRD_L);
    assign w_pipe_hit  = w_x_overlap && ((w_bird_y < w_gap_y) || (w_bird_b > w_gap_b));
    assign w_floor_hit = (w_bird_b >= C_FLOOR);
    assign w_hit       = w_pipe_hit || w_floor_hit;
    assign w_passed    = (w_pipe_r < C_BIRD_L);

    assign w_start_rise  = i_start & ~r_start_q;
    assign w_step        = i_tick & ~i_pause;
    assign w_enter_ready = (w_state_next == ST_READY) && (r_state != ST_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_rise) w_state_next = ST_READY;
            ST_READY: if (w_step && (r_ready_cnt == CNT_LAST)) w_state_next = ST_PLAY;
            ST_PLAY:  if (w_step && w_hit) w_state_next = ST_OVER;
            ST_OVER:  if (w_start_rise) w_state_next = ST_READY;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_status    = r_state;
        o_game_over = r_game_over;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q     <= 1'b0;
            r_ready_cnt   <= '0;
            r_prev_passed <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_start_q   <= i_start;
            r_game_over <= (r_state == ST_PLAY) && w_step && w_hit;

            if (w_enter_ready) begin
                r_ready_cnt <= '0;
            end else if ((r_state == ST_READY) && w_step) begin
                r_ready_cnt <= (r_ready_cnt == CNT_LAST) ? '0 : r_ready_cnt + 1'b1;
            end

            // Seeding on PLAY entry keeps an already-passed pipe from scoring
            if ((r_state == ST_READY) && (w_state_next == ST_PLAY)) begin
                r_prev_passed <= w_passed;
            end else if ((r_state == ST_PLAY) && w_step) begin
                r_prev_passed <= w_passed;
            end
        end
    end

    assign w_score_clr = w_enter_ready;
    assign w_score_inc = (r_state == ST_PLAY) && w_step && !w_hit && w_passed && !r_prev_passed;

    bcd2_counter u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_score_clr),
        .i_inc (w_score_inc),
        .o_q   (o_score)
    );

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for READY timing, scoring runs and async reset.
`timescale 1ns/1ps
module tb_game_ctrl;

    logic               clk;
    logic               rst_n;
    logic               tick;
    logic               start;
    logic               pause;
    logic signed [10:0] bird_y;
    logic signed [10:0] pipe_x;
    logic signed [10:0] gap_y;
    logic [1:0]         status;
    logic [7:0]         score;
    logic               game_over;

    int checks = 0;
    int errors = 0;

    game_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tick      (tick),
        .i_start     (start),
        .i_pause     (pause),
        .i_bird_y    (bird_y),
        .i_pipe_x    (pipe_x),
        .i_gap_y     (gap_y),
        .o_status    (status),
        .o_score     (score),
        .o_game_over (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic       t;
        logic       s;
        logic       p;
        int         by;
        int         px;
        int         gy;
        logic [1:0] st;
        logic [7:0] sc;
        logic       go;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [7:0] to_bcd(input int n);
        int m;
        m = n % 100;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    // Drive one cycle of inputs, then sample 1ns after the active edge
    task automatic drive(input logic t, input logic s, input logic p,
                         input int by, input int px, input int gy);
        tick   = t;
        start  = s;
        pause  = p;
        bird_y = 11'(by);
        pipe_x = 11'(px);
        gap_y  = 11'(gy);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] st,
                         input logic [7:0] sc, input logic go);
        checks++;
        if (status !== st || score !== sc || game_over !== go) begin
            errors++;
            $display("FAIL %s: got status=%0d score=%h game_over=%b, want status=%0d score=%h game_over=%b",
                     name, status, score, game_over, st, sc, go);
        end else begin
            $display("ok   %s: status=%0d score=%h game_over=%b", name, status, score, game_over);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Tick through READY until PLAY appears; returns the tick count (bounded)
    task automatic run_ready(input logic s, input int px, output int n);
        n = 0;
        while (status != 2'd2 && n < 100) begin
            drive(1'b1, s, 1'b0, 200, px, 150);
            n++;
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{"paused_floor",   1'b1, 1'b0, 1'b1, 445, -70, 150, 2'd2, 8'h01, 1'b0};
        vecs[1] = '{"no_tick_floor",  1'b0, 1'b0, 1'b0, 445, -70, 150, 2'd2, 8'h01, 1'b0};
        vecs[2] = '{"floor_miss_444", 1'b1, 1'b0, 1'b0, 444, 300, 150, 2'd2, 8'h01, 1'b0};
        vecs[3] = '{"pipe_hit",       1'b1, 1'b0, 1'b0, 100, 110, 150, 2'd3, 8'h01, 1'b1};
        vecs[4] = '{"go_pulse_end",   1'b0, 1'b0, 1'b0, 100, 110, 150, 2'd3, 8'h01, 1'b0};
        vecs[5] = '{"over_frozen",    1'b1, 1'b0, 1'b0, 200, 30,  150, 2'd3, 8'h01, 1'b0};
        vecs[6] = '{"over_restart",   1'b0, 1'b1, 1'b0, 200, 200, 150, 2'd1, 8'h00, 1'b0};
        vecs[7] = '{"ready_start_hi", 1'b1, 1'b1, 1'b0, 200, 200, 150, 2'd1, 8'h00, 1'b0};

        tick = 0; start = 0; pause = 0; bird_y = 0; pipe_x = 0; gap_y = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_state", 2'd0, 8'h00, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive(1'b0, 1'b0, 1'b0, 200, 300, 150);
        check("idle_hold", 2'd0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 200, 300, 150);
        check("start_to_ready", 2'd1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 200, 300, 150);
        check("ready_paused", 2'd1, 8'h00, 1'b0);
        run_ready(1'b0, 300, n);
        check_int("ready_ticks_1", n, 64);

        for (int px = 300; px >= -70; px--) begin
            drive(1'b1, 1'b0, 1'b0, 200, px, 150);
            check($sformatf("sweep_px%0d", px), 2'd2, (px < 40) ? 8'h01 : 8'h00, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].t, vecs[i].s, vecs[i].p, vecs[i].by, vecs[i].px, vecs[i].gy);
            check(vecs[i].name, vecs[i].st, vecs[i].sc, vecs[i].go);
        end

        run_ready(1'b1, 200, n);
        check_int("ready_ticks_2", n, 63);
        drive(1'b1, 1'b1, 1'b0, 444, 200, 150);
        check("floor_444_play", 2'd2, 8'h00, 1'b0);

        for (int k = 1; k <= 100; k++) begin
            drive(1'b1, 1'b1, 1'b0, 200, 30, 150);
            check($sformatf("pass_%0d", k), 2'd2, to_bcd(k), 1'b0);
            drive(1'b1, 1'b1, 1'b0, 200, 200, 150);
            check($sformatf("rearm_%0d", k), 2'd2, to_bcd(k), 1'b0);
        end

        drive(1'b1, 1'b1, 1'b0, 445, 30, 150);
        check("hit_and_pass", 2'd3, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 200, 200, 150);
            check("over_start_held", 2'd3, 8'h00, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 200, 200, 150);
        check("over_start_low", 2'd3, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 200, 200, 150);
        check("over_to_ready", 2'd1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 200, 200, 150);
            check("ready_start_held", 2'd1, 8'h00, 1'b0);
        end

        run_ready(1'b1, 200, n);
        check_int("ready_ticks_3", n, 64);
        drive(1'b1, 1'b1, 1'b0, 200, 30, 150);
        check("pass_before_reset", 2'd2, 8'h01, 1'b0);

        #3 rst_n = 1'b0;
        #1 check("async_reset", 2'd0, 8'h00, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 445, 110, 150);
        check("post_reset_idle", 2'd0, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
